hdub_core_logic_bin_gate_seq: RTL and testbench
===============================================

HDUB_CORE_LOGIC_BIN_GATE_SEQ -- requirements
Module: hdub_core_logic_bin_gate_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8: bits processed per cycle; SHALL divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted when in_valid and in_ready are both high at a clock edge.
REQ-007 in_op  input  2  gate select, encoded as the shared gate-type enum.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  result consumed when out_valid and out_ready are both high at a clock edge.
REQ-012 out_result  output  WIDTH  bitwise result.
REQ-013 out_err  output  1  the request carried an unsupported op code.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be high in IDLE, and in DONE when out_ready is high; it SHALL be low in RUN.
REQ-016 On accept:
- in_op, in_a and in_b SHALL be captured, the chunk index cleared to 0, and the state SHALL go to RUN.
- in_a and in_b SHALL NOT be sampled again for that request.
REQ-017 RUN processing, per cycle:
- Chunk index k SHALL have AND, OR or XOR applied to bits [k*CHUNK +: CHUNK] of the captured operands.
- The result SHALL be written to the same slice of the result register.
- k SHALL increment by 1.
REQ-018 After the last chunk (k = WIDTH/CHUNK-1) the state SHALL go to DONE and out_valid SHALL assert.
- Latency: out_valid high exactly WIDTH/CHUNK cycles after the accept edge (4 at defaults).
REQ-019 In DONE, out_result and out_err SHALL stay stable while out_valid is high and out_ready is low.
REQ-020 In DONE with out_ready high:
- With no new accept, the state SHALL go to IDLE.
- With a simultaneous accept, the state SHALL go directly to RUN (back-to-back) and out_valid SHALL deassert.
REQ-021 op code 3 (unsupported) SHALL still complete in WIDTH/CHUNK cycles, with out_result all zeros and out_err = 1.
- Supported ops SHALL give out_err = 0.
REQ-022 The chunk index SHALL be exactly log2(WIDTH/CHUNK) bits wide, with a minimum of 1 bit, and SHALL NOT wrap during RUN.
REQ-023 With WIDTH == CHUNK the block SHALL spend exactly one RUN cycle per request.

Reset
REQ-024 With rst_n low at an edge, the state SHALL go to IDLE from any state, including mid-RUN; the in-flight request SHALL be discarded.
REQ-025 Reset values SHALL be: out_valid = 0, out_err = 0, out_result = 0, chunk index = 0.
REQ-026 in_ready SHALL be low while rst_n is low and high on the first cycle after release.

Configuration
REQ-027 Macro HDUB_CORE_LOGIC_BIN_GATE_SEQ_ZFLAG_EN, when defined, SHALL add output out_zero (1 bit).
- out_zero SHALL be high when out_valid is high and out_result == 0.
- It SHALL be accumulated per chunk during RUN, with no extra cycle.
- It SHALL reset to 0.
REQ-028 Without the macro, the out_zero port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-029 Package hdub_core_logic_gate SHALL hold:
- the gate-type enum (GATE_AND = 0, GATE_OR = 1, GATE_XOR = 2);
- a new seq state enum (IDLE, RUN, DONE).
REQ-030 Sub-module hdub_core_logic_bin_gate_chunk SHALL be instantiated once. It is combinational, CHUNK wide, and has run-time op select and an err output.

Verification
REQ-031 Defaults, GATE_AND, a=0xF0F0_1234, b=0xFF00_00FF, out_ready held high -> out_valid exactly 4 cycles after accept; out_result=0xF000_0034; out_err=0.
REQ-032 GATE_XOR, a=b=0xDEAD_BEEF -> out_result=0; out_zero=1 with the macro defined; port absent without it.
REQ-033 GATE_OR with out_ready low for 5 cycles -> out_valid and out_result (0xFF..., from a=0xFFFF_0000, b=0x0000_FFFF) stable throughout; in_ready low.
REQ-034 Two back-to-back requests, second in_valid held high during DONE with out_ready=1 -> no IDLE cycle between them; second out_valid 4 cycles after the handshake.
REQ-035 op=3 -> out_err=1, out_result=0, same latency.
REQ-036 rst_n low for 1 cycle at the 2nd RUN cycle -> out_valid never asserts for that request; in_ready high the cycle after release; next request is correct.

Source files
------------

// File: rtl/hdub_core_logic_bin_gate_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdub_core_logic_gate (package)
// Brief    : Gate-type and sequencer-state enums shared by the bin-gate slice.
// Revision : 1.0 - initial release
// ============================================================================
package hdub_core_logic_gate;

    typedef enum logic [1:0] {
        GATE_AND = 2'd0,
        GATE_OR  = 2'd1,
        GATE_XOR = 2'd2
    } gate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Chunk index width; a single-chunk build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdub_core_logic_bin_gate_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : hdub_core_logic_bin_gate_seq_if
// Brief    : Request/result handshake bundle. HDUB_CORE_LOGIC_BIN_GATE_SEQ_ZFLAG_EN
//            adds the out_zero signal.
// Revision : 1.0 - initial release
// ============================================================================
interface hdub_core_logic_bin_gate_seq_if
    import hdub_core_logic_gate::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    gate_t            in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;
`ifdef HDUB_CORE_LOGIC_BIN_GATE_SEQ_ZFLAG_EN
    logic             out_zero;
`endif

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_err
`ifdef HDUB_CORE_LOGIC_BIN_GATE_SEQ_ZFLAG_EN
        , input out_zero
`endif
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_err
`ifdef HDUB_CORE_LOGIC_BIN_GATE_SEQ_ZFLAG_EN
        , output out_zero
`endif
    );

endinterface
`default_nettype wire

// File: rtl/hdub_core_logic_bin_gate_chunk.sv
`default_nettype none
// ============================================================================
// Module   : hdub_core_logic_bin_gate_chunk
// Brief    : Combinational CHUNK-wide AND/OR/XOR with unsupported-op flag.
// Revision : 1.0 - initial release
// ============================================================================
module hdub_core_logic_bin_gate_chunk
    import hdub_core_logic_gate::*;
#(
    parameter int CHUNK = 8
) (
    input  gate_t            i_op,
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic [CHUNK-1:0] o_y,
    output logic             o_err
);

    always_comb begin
        o_y   = '0;
        o_err = 1'b0;
        case (i_op)
            GATE_AND: o_y = i_a & i_b;
            GATE_OR:  o_y = i_a | i_b;
            GATE_XOR: o_y = i_a ^ i_b;
            default:  o_err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hdub_core_logic_bin_gate_seq.sv
`default_nettype none
// ============================================================================
// Module   : hdub_core_logic_bin_gate_seq
// Brief    : Bit-serial (CHUNK bits/cycle) bitwise gate with valid/ready
//            handshake. Define HDUB_CORE_LOGIC_BIN_GATE_SEQ_ZFLAG_EN for out_zero.
// Revision : 1.0 - initial release
// ============================================================================
module hdub_core_logic_bin_gate_seq
    import hdub_core_logic_gate::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    hdub_core_logic_bin_gate_seq_if.slave  bus
);

    localparam int                 c_NCHUNK = WIDTH / CHUNK;
    localparam int                 c_IDX_W  = idx_width(c_NCHUNK);
    localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(c_NCHUNK - 1);

    seq_state_t         r_state;
    logic [c_IDX_W-1:0] r_idx;
    gate_t              r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_valid;
    logic               r_err;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_y;
    logic               w_err;

    // Gated by rst_n so the port reads low for the whole reset window.
    assign w_in_ready = rst_n && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_idx == c_LAST);
    assign w_a_chunk  = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk  = r_b[r_idx*CHUNK +: CHUNK];

    hdub_core_logic_bin_gate_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_op  (r_op),
        .i_a   (w_a_chunk),
        .i_b   (w_b_chunk),
        .o_y   (w_y),
        .o_err (w_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_op     <= GATE_AND;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_result[r_idx*CHUNK +: CHUNK] <= w_y;
                    if (w_last) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_err   <= w_err;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: ;
            endcase
            // Accept overrides the DONE->IDLE move so back-to-back skips IDLE.
            if (w_accept) begin
                r_op    <= bus.in_op;
                r_a     <= bus.in_a;
                r_b     <= bus.in_b;
                r_idx   <= '0;
                r_state <= RUN;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_valid;
    assign bus.out_result = r_result;
    assign bus.out_err    = r_err;

`ifdef HDUB_CORE_LOGIC_BIN_GATE_SEQ_ZFLAG_EN
    logic r_zacc;
    logic r_zero;
    logic w_chunk_zero;

    assign w_chunk_zero = ~|w_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zacc <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_zacc <= 1'b1;
            end else if (r_state == RUN) begin
                r_zacc <= r_zacc & w_chunk_zero;
            end
            if ((r_state == RUN) && w_last) begin
                r_zero <= r_zacc & w_chunk_zero;
            end else if ((r_state == DONE) && bus.out_ready) begin
                r_zero <= 1'b0;
            end
        end
    end

    assign bus.out_zero = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdub_core_logic_bin_gate_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdub_core_logic_bin_gate_seq
// Brief    : Directed + random checks against a whole-word reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdub_core_logic_bin_gate_seq;
    import hdub_core_logic_gate::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errs   = 0;
    int   checks = 0;

    hdub_core_logic_bin_gate_seq_if #(.WIDTH(32)) bus ();
    hdub_core_logic_bin_gate_seq_if #(.WIDTH(8))  bus1 ();

    hdub_core_logic_bin_gate_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hdub_core_logic_bin_gate_seq #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = gate_t'(op);
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_wait", 64'(n < 50), 64'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_op    = gate_t'(2'($urandom));
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
    endtask

    task automatic expect_done(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int stall);
        int          lat = 0;
        logic [31:0] exp;
        exp = model(op, a, b);
        chk("in_ready_run", 64'(bus.in_ready), 64'd0);
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("result", 64'(bus.out_result), 64'(exp));
        chk("err", 64'(bus.out_err), 64'(op == 2'd3));
`ifdef HDUB_CORE_LOGIC_BIN_GATE_SEQ_ZFLAG_EN
        chk("zero", 64'(bus.out_zero), 64'(exp == 32'h0));
`endif
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_result", 64'(bus.out_result), 64'(exp));
            chk("stall_err", 64'(bus.out_err), 64'(op == 2'd3));
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        chk("consumed", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] a2;
        logic [31:0] b2;
        int          stall;
        logic        seen;

        bus.in_valid   = 1'b0;
        bus.in_op      = GATE_AND;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_op     = GATE_AND;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
`ifdef HDUB_CORE_LOGIC_BIN_GATE_SEQ_ZFLAG_EN
        chk("rst_out_zero", 64'(bus.out_zero), 64'd0);
`endif
        rst_n = 1'b1;
        step();
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);

        // AND directed vector
        send(2'd0, 32'hF0F0_1234, 32'hFF00_00FF);
        expect_done(2'd0, 32'hF0F0_1234, 32'hFF00_00FF, 0);
        chk("and_vector", 64'(bus.out_result), 64'h0000_0000_F000_0034);
        consume();

        // XOR to zero
        send(2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        expect_done(2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        consume();

        // OR with back-pressure
        bus.out_ready = 1'b0;
        send(2'd1, 32'hFFFF_0000, 32'h0000_FFFF);
        expect_done(2'd1, 32'hFFFF_0000, 32'h0000_FFFF, 5);
        chk("or_vector", 64'(bus.out_result), 64'h0000_0000_FFFF_FFFF);
        consume();

        // Unsupported op
        a = $urandom;
        b = $urandom;
        send(2'd3, a, b);
        expect_done(2'd3, a, b, 0);
        consume();

        // Back-to-back: second request accepted in DONE
        a  = $urandom;
        b  = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        send(2'd0, a, b);
        expect_done(2'd0, a, b, 0);
        chk("b2b_in_ready_done", 64'(bus.in_ready), 64'd1);
        send(2'd2, a2, b2);
        chk("b2b_valid_drop", 64'(bus.out_valid), 64'd0);
        expect_done(2'd2, a2, b2, 0);
        consume();

        // Reset during the second RUN cycle
        send(2'd1, $urandom, $urandom);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("discarded_request", 64'(seen), 64'd0);
        a = $urandom;
        b = $urandom;
        send(2'd0, a, b);
        expect_done(2'd0, a, b, 0);
        consume();

        // Random traffic
        for (int i = 0; i < 8; i++) begin
            op    = 2'($urandom_range(0, 3));
            a     = $urandom;
            b     = $urandom;
            stall = $urandom_range(0, 2);
            bus.out_ready = (stall == 0);
            send(op, a, b);
            expect_done(op, a, b, stall);
            consume();
        end

        // Single-chunk build: one RUN cycle
        bus1.in_valid = 1'b1;
        bus1.in_op    = GATE_XOR;
        bus1.in_a     = 8'h5A;
        bus1.in_b     = 8'h0F;
        chk("w8_in_ready", 64'(bus1.in_ready), 64'd1);
        step();
        bus1.in_valid = 1'b0;
        chk("w8_in_ready_run", 64'(bus1.in_ready), 64'd0);
        step();
        chk("w8_valid", 64'(bus1.out_valid), 64'd1);
        chk("w8_result", 64'(bus1.out_result), 64'h55);
        step();
        chk("w8_consumed", 64'(bus1.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
